dmem_port_arbiter: RTL and testbench



---
 rtl/dmem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single synchronous data-RAM port between the
// pipeline MEM stage (fixed priority) and a DMA requester served in idle
// slots. Read data is steered back to its owner through a tag pipe that is
// RD_LAT stages deep.
// Optional feature macro: DMEM_ARB_STARVE_EN adds a DMA starvation counter.
// When the counter saturates, it forces one DMA slot by stalling the pipeline
// for a single cycle.
module dmem_port_arbiter #(
  parameter int AW       = 17,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_rd,
  input  logic          pipe_wr,
  input  logic [31:0]   pipe_addr,
  input  logic [DW-1:0] pipe_wdata,
  output logic [DW-1:0] pipe_rdata,
  output logic          pipe_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

`ifdef DMEM_ARB_STARVE_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PIPE  = 2'd1,
    S_DMA   = 2'd2,
    S_FORCE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PIPE = 2'd1,
    S_DMA  = 2'd2
  } state_t;
`endif

  state_t      state_r;
  logic        pipe_act_s;
  logic        force_s;
  logic        pipe_gnt_s;
  logic        dma_gnt_s;
  logic        stall_s;
  logic [RD_LAT-1:0] tag_v_r;
  logic [RD_LAT-1:0] tag_dma_r;
  logic        ret_v_s;
  logic        ret_dma_s;
  logic [DW-1:0] hold_r;
  logic        unused_s;

  assign pipe_act_s = pipe_rd | pipe_wr;

`ifdef DMEM_ARB_STARVE_EN
  logic [7:0] wait_cnt_r;

  // The cycle after a forced slot masks force, so a pipeline stall never
  // lasts longer than one cycle.
  assign force_s  = dma_req && (wait_cnt_r == 8'(MAX_WAIT)) && (state_r != S_FORCE);
  assign unused_s = ^pipe_addr[31:AW];

  // Starvation counter: counts cycles that a DMA request waits, saturating at MAX_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
    end else if (dma_gnt_s || !dma_req) begin
      wait_cnt_r <= 8'd0;
    end else if (wait_cnt_r != 8'(MAX_WAIT)) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  assign force_s  = 1'b0;
  assign unused_s = ^{pipe_addr[31:AW], state_r, 8'(MAX_WAIT)};
`endif

  // Grant and port mux: the pipeline wins unless force is set, DMA takes any other slot.
  always_comb begin
    pipe_gnt_s = 1'b0;
    dma_gnt_s  = 1'b0;
    stall_s    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = {AW{1'b0}};
    mem_wdata  = {DW{1'b0}};
    if (reset) begin
      pipe_gnt_s = 1'b0;
    end else if (pipe_act_s && !force_s) begin
      pipe_gnt_s = 1'b1;
      mem_wr     = pipe_wr;
      mem_rd     = ~pipe_wr;
      mem_addr   = pipe_addr[AW-1:0];
      mem_wdata  = pipe_wr ? pipe_wdata : {DW{1'b0}};
    end else if (dma_req) begin
      dma_gnt_s  = 1'b1;
      stall_s    = pipe_act_s;
      mem_wr     = dma_we;
      mem_rd     = ~dma_we;
      mem_addr   = dma_addr;
      mem_wdata  = dma_we ? dma_wdata : {DW{1'b0}};
    end else begin
      dma_gnt_s  = 1'b0;
    end
  end

  assign dma_gnt = dma_gnt_s;
`ifdef DMEM_ARB_STARVE_EN
  assign pipe_stall = stall_s;
`else
  assign pipe_stall = 1'b0;
`endif

  // Grant-history state: records who owned the port in the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
`ifdef DMEM_ARB_STARVE_EN
    end else if (force_s && pipe_act_s) begin
      state_r <= S_FORCE;
`endif
    end else if (dma_gnt_s) begin
      state_r <= S_DMA;
    end else if (pipe_gnt_s) begin
      state_r <= S_PIPE;
    end else begin
      state_r <= S_IDLE;
    end
  end

  // Tag pipe: one {valid, owner} entry per issued read, aligned to the RAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v_r   <= {RD_LAT{1'b0}};
      tag_dma_r <= {RD_LAT{1'b0}};
    end else begin
      tag_v_r[0]   <= mem_rd;
      tag_dma_r[0] <= dma_gnt_s;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_r[i]   <= tag_v_r[i-1];
        tag_dma_r[i] <= tag_dma_r[i-1];
      end
    end
  end

  assign ret_v_s   = tag_v_r[RD_LAT-1];
  assign ret_dma_s = tag_dma_r[RD_LAT-1];

  // Read return: register DMA data with a one-cycle valid, and latch pipeline data into the hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= {DW{1'b0}};
      hold_r     <= {DW{1'b0}};
    end else begin
      dma_rvalid <= ret_v_s & ret_dma_s;
      if (ret_v_s && ret_dma_s) begin
        dma_rdata <= mem_rdata;
      end else begin
        dma_rdata <= dma_rdata;
      end
      if (ret_v_s && !ret_dma_s) begin
        hold_r <= mem_rdata;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  assign pipe_rdata = (ret_v_s && !ret_dma_s) ? mem_rdata : hold_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous RAM model
// (one-cycle read latency). MAX_WAIT is set to 3 so the starvation case is short.
module tb_dmem_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_rd, pipe_wr;
  logic [31:0]   pipe_addr;
  logic [DW-1:0] pipe_wdata, pipe_rdata;
  logic          pipe_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          pre_we;
  logic [7:0]    pre_addr;
  logic [31:0]   pre_data;
  logic [31:0]   ram [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: one-cycle read latency, plus a preload port used only while the DUT is in reset
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_wr) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pipe_rd = 1'b0; pipe_wr = 1'b0; pipe_addr = 32'd0; pipe_wdata = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 17'd0; dma_wdata = 32'd0;
    pre_we = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
    mem_rdata = 32'd0;
    preload(8'h10, 32'hCAFE0001);
    preload(8'h20, 32'h12345678);
    preload(8'h01, 32'h00000011);
    preload(8'h02, 32'h00000022);
    preload(8'h03, 32'h00000033);
    preload(8'h05, 32'h00000000);
    preload(8'h07, 32'h00000000);
    @(negedge clk);
    chk("rst_gnt",    {31'd0, dma_gnt},    32'd0);
    chk("rst_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("rst_memrd",  {31'd0, mem_rd},     32'd0);
    chk("rst_prdata", pipe_rdata,          32'd0);
    chk("rst_drdata", dma_rdata,           32'd0);
    tick();
    reset = 1'b0;

    // pipeline read only
    tick();
    pipe_rd = 1'b1; pipe_addr = 32'h10;
    @(negedge clk);
    chk("p_memrd",  {31'd0, mem_rd},     32'd1);
    chk("p_addr",   {15'd0, mem_addr},   32'h10);
    chk("p_stall",  {31'd0, pipe_stall}, 32'd0);
    tick();
    pipe_rd = 1'b0;
    @(negedge clk);
    chk("p_rdata",  pipe_rdata, 32'hCAFE0001);

    // DMA read in idle slots
    tick();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h20;
    @(negedge clk);
    chk("d_gnt",    {31'd0, dma_gnt},    32'd1);
    chk("d_addr",   {15'd0, mem_addr},   32'h20);
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    chk("d_rv_n1",  {31'd0, dma_rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("d_rv_n2",  {31'd0, dma_rvalid}, 32'd1);
    chk("d_rdata",  dma_rdata,           32'h12345678);
    tick();
    @(negedge clk);
    chk("d_rv_n3",  {31'd0, dma_rvalid}, 32'd0);

    // starvation under continuous pipeline reads
    tick();
    pipe_rd = 1'b1; pipe_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h5; dma_wdata = 32'hAA;
`ifdef DMEM_ARB_STARVE_EN
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("s_gnt_wait",   {31'd0, dma_gnt},    32'd0);
      chk("s_stall_wait", {31'd0, pipe_stall}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("s_gnt_force",   {31'd0, dma_gnt},    32'd1);
    chk("s_stall_force", {31'd0, pipe_stall}, 32'd1);
    chk("s_memwr_force", {31'd0, mem_wr},     32'd1);
    chk("s_addr_force",  {15'd0, mem_addr},   32'h5);
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    chk("s_stall_after", {31'd0, pipe_stall}, 32'd0);
    chk("s_memrd_after", {31'd0, mem_rd},     32'd1);
    chk("s_addr_after",  {15'd0, mem_addr},   32'h10);
    tick();
    pipe_rd = 1'b0;
`else
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("s_gnt_strict",   {31'd0, dma_gnt},    32'd0);
      chk("s_stall_strict", {31'd0, pipe_stall}, 32'd0);
      tick();
    end
    pipe_rd = 1'b0;
    @(negedge clk);
    chk("s_gnt_idle",   {31'd0, dma_gnt}, 32'd1);
    chk("s_memwr_idle", {31'd0, mem_wr},  32'd1);
    tick();
    dma_req = 1'b0;
`endif
    tick();
    pipe_rd = 1'b1; pipe_addr = 32'h5;
    tick();
    pipe_rd = 1'b0;
    @(negedge clk);
    chk("s_ram5", pipe_rdata, 32'hAA);

    // interleaved ownership
    tick();
    pipe_rd = 1'b1; pipe_addr = 32'h1;
    tick();
    pipe_rd = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h2;
    @(negedge clk);
    chk("i_gnt",     {31'd0, dma_gnt}, 32'd1);
    chk("i_prd_c1",  pipe_rdata,       32'h11);
    tick();
    dma_req = 1'b0;
    pipe_rd = 1'b1; pipe_addr = 32'h3;
    @(negedge clk);
    chk("i_prd_c2",  pipe_rdata,          32'h11);
    chk("i_rv_c2",   {31'd0, dma_rvalid}, 32'd0);
    tick();
    pipe_rd = 1'b0;
    @(negedge clk);
    chk("i_prd_c3",  pipe_rdata,          32'h33);
    chk("i_rv_c3",   {31'd0, dma_rvalid}, 32'd1);
    chk("i_drd_c3",  dma_rdata,           32'h22);
    tick();
    @(negedge clk);
    chk("i_rv_c4",   {31'd0, dma_rvalid}, 32'd0);
    chk("i_prd_c4",  pipe_rdata,          32'h33);

    // simultaneous read and write is a write
    tick();
    pipe_rd = 1'b1; pipe_wr = 1'b1; pipe_addr = 32'h7; pipe_wdata = 32'h99;
    @(negedge clk);
    chk("w_memwr",  {31'd0, mem_wr}, 32'd1);
    chk("w_memrd",  {31'd0, mem_rd}, 32'd0);
    chk("w_wdata",  mem_wdata,       32'h99);
    tick();
    pipe_rd = 1'b0; pipe_wr = 1'b0;
    @(negedge clk);
    chk("w_notag",  pipe_rdata,      32'h33);
    tick();
    pipe_rd = 1'b1; pipe_addr = 32'h7;
    tick();
    pipe_rd = 1'b0;
    @(negedge clk);
    chk("w_ram7",   pipe_rdata,      32'h99);

    // reset one cycle after a DMA read grant
    tick();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h20;
    @(negedge clk);
    chk("r_gnt",    {31'd0, dma_gnt}, 32'd1);
    tick();
    dma_req = 1'b0;
    reset = 1'b1;
    pipe_rd = 1'b1; pipe_addr = 32'h10;
    #1;
    chk("r_memrd",  {31'd0, mem_rd},     32'd0);
    chk("r_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("r_prdata", pipe_rdata,          32'd0);
    chk("r_drdata", dma_rdata,           32'd0);
    pipe_rd = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("r_no_rvalid", {31'd0, dma_rvalid}, 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
